// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t    : FSM state encoding (IDLE, CALC, DONE), 2 bits wide.
//   cnt_width  : width of the iteration counter for a given operand width.
//                It must be able to hold WIDTH, the value the counter reaches
//                after the final iteration.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/RippleCarryAdder.sv
// Ripple-carry adder: sum/cout = a + b + cin, WIDTH bits.
// Ports:
//   a, b : input  WIDTH  addends
//   cin  : input  1      carry in
//   sum  : output WIDTH  sum bits
//   cout : output 1      carry out of the MSB
module RippleCarryAdder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   // One full-adder cell per bit position, carry chained upward.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned WIDTH x WIDTH multiplier, one shift-and-add per clock.
// Ports:
//   clk         : input  1        rising-edge clock
//   rst_n       : input  1        asynchronous active-low reset
//   in_valid    : input  1        operands present on in_a/in_b
//   in_ready    : output 1        block can accept operands (IDLE)
//   in_a        : input  WIDTH    multiplicand
//   in_b        : input  WIDTH    multiplier
//   out_valid   : output 1        out_product holds a result (DONE)
//   out_ready   : input  1        consumer accepts the result
//   out_product : output 2*WIDTH  in_a * in_b
//   busy        : output 1        high in CALC or DONE
// Operation: {acc_hi, acc_lo} starts as {0, in_b}. Each CALC cycle adds the
// multiplicand into acc_hi when acc_lo[0] is set and shifts the whole
// accumulator (including the adder carry) right by one. After WIDTH cycles
// the multiplier bits have all been consumed and the product fills the
// accumulator.
module shift_add_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 busy
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  ONE  = CW'(1);

   state_t              state_q,  state_d;
   logic [CW-1:0]       count_q,  count_d;
   logic [WIDTH-1:0]    mcand_q,  mcand_d;
   logic [WIDTH-1:0]    acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]    acc_lo_q, acc_lo_d;

   logic [WIDTH-1:0]    add_b;
   logic [WIDTH-1:0]    add_sum;
   logic                add_cout;

   // Partial product for this iteration: multiplicand gated by the current
   // low multiplier bit, which always sits in acc_lo[0].
   assign add_b = acc_lo_q[0] ? mcand_q : '0;

   RippleCarryAdder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (acc_hi_q),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)         state_d = CALC;
         CALC:    if (count_q == LAST)  state_d = DONE;
         DONE:    if (out_ready)        state_d = IDLE;
         default:                       state_d = IDLE;
      endcase
   end

   // Datapath next values. Registers hold outside of accept and CALC, so the
   // product stays put through DONE and after the output handshake.
   always_comb begin
      count_d  = count_q;
      mcand_d  = mcand_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      if (state_q == IDLE && in_valid) begin
         mcand_d  = in_a;
         acc_hi_d = '0;
         acc_lo_d = in_b;
         count_d  = '0;
      end else if (state_q == CALC) begin
         // (2*WIDTH+1)-bit {cout, sum, acc_lo} shifted right by one; the
         // carry lands in the top bit so nothing is lost.
         {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};
         count_d              = count_q + ONE;
      end
   end

   // Outputs decoded from the state register only.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == CALC) || (state_q == DONE);
   end

   assign out_product = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier at WIDTH=8 and WIDTH=16.
module tb_shift_add_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH = 8 instance
   logic        rst8_n;
   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [7:0]  in_a8, in_b8;
   logic [15:0] out_product8;

   // WIDTH = 16 instance
   logic        rst16_n;
   logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
   logic [15:0] in_a16, in_b16;
   logic [31:0] out_product16;

   int total = 0;
   int bad   = 0;
   logic done16 = 1'b0;

   shift_add_multiplier #(.WIDTH(8)) dut8 (
      .clk         (clk),
      .rst_n       (rst8_n),
      .in_valid    (in_valid8),
      .in_ready    (in_ready8),
      .in_a        (in_a8),
      .in_b        (in_b8),
      .out_valid   (out_valid8),
      .out_ready   (out_ready8),
      .out_product (out_product8),
      .busy        (busy8)
   );

   shift_add_multiplier #(.WIDTH(16)) dut16 (
      .clk         (clk),
      .rst_n       (rst16_n),
      .in_valid    (in_valid16),
      .in_ready    (in_ready16),
      .in_a        (in_a16),
      .in_b        (in_b16),
      .out_valid   (out_valid16),
      .out_ready   (out_ready16),
      .out_product (out_product16),
      .busy        (busy16)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // ---------------- WIDTH = 8 helpers ----------------
   // Returns at the falling edge right after the accepting rising edge.
   task automatic accept8(input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      in_a8 = a; in_b8 = b; in_valid8 = 1'b1;
      while (!in_ready8 && n < 300) begin @(negedge clk); n++; end
      if (!in_ready8) check_eq("accept8_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
   endtask

   // Counts cycles from the accept until out_valid is seen.
   task automatic wait_out8(output int lat);
      lat = 0;
      while (!out_valid8 && lat < 300) begin @(negedge clk); lat++; end
      if (!out_valid8) check_eq("wait8_timeout", 32'd0, 32'd1);
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp);
      int lat;
      accept8(a, b);
      check_eq({tag, "_busy"}, 32'(busy8), 32'd1);
      check_eq({tag, "_inrdy_busy"}, 32'(in_ready8), 32'd0);
      wait_out8(lat);
      check_eq({tag, "_lat"}, 32'(lat), 32'd8);
      check_eq({tag, "_prod"}, 32'(out_product8), 32'(exp));
      check_eq({tag, "_nobypass"}, 32'(in_ready8), 32'd0);
      $display("tx w8 %s a=%0d b=%0d product=%0d latency=%0d", tag, a, b, out_product8, lat);
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      check_eq({tag, "_inrdy_after"}, 32'(in_ready8), 32'd1);
      check_eq({tag, "_ovalid_after"}, 32'(out_valid8), 32'd0);
      check_eq({tag, "_prod_kept"}, 32'(out_product8), 32'(exp));
   endtask

   // ---------------- WIDTH = 16 helpers ----------------
   task automatic accept16(input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      @(negedge clk);
      in_a16 = a; in_b16 = b; in_valid16 = 1'b1;
      while (!in_ready16 && n < 300) begin @(negedge clk); n++; end
      if (!in_ready16) check_eq("accept16_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid16 = 1'b0;
   endtask

   task automatic wait_out16(output int lat);
      lat = 0;
      while (!out_valid16 && lat < 300) begin @(negedge clk); lat++; end
      if (!out_valid16) check_eq("wait16_timeout", 32'd0, 32'd1);
   endtask

   // ---------------- WIDTH = 8 directed + random ----------------
   initial begin
      logic [15:0] q8[$];
      int          n_acc8, n_res8, lat, n;
      logic        stray;

      rst8_n = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; in_a8 = '0; in_b8 = '0;
      #12;
      check_eq("rst_inrdy", 32'(in_ready8), 32'd1);
      check_eq("rst_ovalid", 32'(out_valid8), 32'd0);
      check_eq("rst_busy", 32'(busy8), 32'd0);
      check_eq("rst_prod", 32'(out_product8), 32'd0);
      @(negedge clk);
      rst8_n = 1'b1;

      run8("13x11", 8'd13, 8'd11, 16'd143);
      run8("255x255", 8'd255, 8'd255, 16'd65025);
      run8("0x200", 8'd0, 8'd200, 16'd0);
      run8("200x0", 8'd200, 8'd0, 16'd0);
      run8("1x255", 8'd1, 8'd255, 16'd255);

      // Stall the consumer for 5 cycles while new operands are offered.
      accept8(8'd6, 8'd7);
      wait_out8(lat);
      check_eq("hold_lat", 32'(lat), 32'd8);
      for (int k = 0; k < 5; k++) begin
         check_eq("hold_ovalid", 32'(out_valid8), 32'd1);
         check_eq("hold_prod", 32'(out_product8), 32'd42);
         check_eq("hold_inrdy", 32'(in_ready8), 32'd0);
         in_valid8 = 1'b1; in_a8 = 8'd9; in_b8 = 8'd9;
         @(negedge clk);
      end
      in_valid8 = 1'b0;
      check_eq("hold_prod_end", 32'(out_product8), 32'd42);
      $display("tx w8 hold a=6 b=7 product=%0d latency=%0d", out_product8, lat);
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      check_eq("hold_inrdy_after", 32'(in_ready8), 32'd1);
      run8("2x3", 8'd2, 8'd3, 16'd6);

      // Reset during the fourth iteration aborts the operation at once.
      accept8(8'd200, 8'd100);
      repeat (3) @(negedge clk);
      #2 rst8_n = 1'b0;
      #1;
      check_eq("abort_ovalid", 32'(out_valid8), 32'd0);
      check_eq("abort_prod", 32'(out_product8), 32'd0);
      check_eq("abort_inrdy", 32'(in_ready8), 32'd1);
      check_eq("abort_busy", 32'(busy8), 32'd0);
      @(negedge clk);
      rst8_n = 1'b1;
      stray = 1'b0;
      repeat (12) begin @(negedge clk); stray |= out_valid8; end
      check_eq("abort_no_ovalid", 32'(stray), 32'd0);
      $display("tx w8 abort a=200 b=100 product=%0d", out_product8);
      run8("3x5", 8'd3, 8'd5, 16'd15);

      // Random operands with random input and output gaps.
      n_acc8 = 0; n_res8 = 0;
      for (int i = 0; i < 1000; i++) begin
         logic [7:0]  a, b;
         logic [15:0] exp;
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         accept8(a, b);
         q8.push_back(16'(32'(a) * 32'(b)));
         n_acc8++;
         wait_out8(lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         out_ready8 = 1'b1;
         exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
         check_eq("rand8_prod", 32'(out_product8), 32'(exp));
         n_res8++;
         $display("tx w8 rand a=%0d b=%0d product=%0d latency=%0d", a, b, out_product8, lat);
         @(negedge clk);
         out_ready8 = 1'b0;
      end
      check_eq("rand8_count", 32'(n_res8), 32'(n_acc8));
      check_eq("rand8_sb_empty", 32'(q8.size()), 32'd0);

      n = 0;
      while (!done16 && n < 80000) begin @(negedge clk); n++; end
      if (!done16) check_eq("done16_timeout", 32'd0, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- WIDTH = 16 random, concurrent ----------------
   initial begin
      logic [31:0] q16[$];
      int          n_acc16, n_res16, lat;

      rst16_n = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0; in_a16 = '0; in_b16 = '0;
      #12;
      check_eq("rst16_prod", out_product16, 32'd0);
      @(negedge clk);
      rst16_n = 1'b1;

      run16_max: begin
         accept16(16'hFFFF, 16'hFFFF);
         wait_out16(lat);
         check_eq("max16_lat", 32'(lat), 32'd16);
         check_eq("max16_prod", out_product16, 32'hFFFE0001);
         $display("tx w16 max a=65535 b=65535 product=%0d latency=%0d", out_product16, lat);
         out_ready16 = 1'b1;
         @(negedge clk);
         out_ready16 = 1'b0;
      end

      n_acc16 = 0; n_res16 = 0;
      for (int i = 0; i < 1000; i++) begin
         logic [15:0] a, b;
         logic [31:0] exp;
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         accept16(a, b);
         q16.push_back(32'(a) * 32'(b));
         n_acc16++;
         wait_out16(lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         out_ready16 = 1'b1;
         exp = (q16.size() > 0) ? q16.pop_front() : 32'hxxxxxxxx;
         check_eq("rand16_prod", out_product16, exp);
         n_res16++;
         $display("tx w16 rand a=%0d b=%0d product=%0d latency=%0d", a, b, out_product16, lat);
         @(negedge clk);
         out_ready16 = 1'b0;
      end
      check_eq("rand16_count", 32'(n_res16), 32'(n_acc16));
      check_eq("rand16_sb_empty", 32'(q16.size()), 32'd0);
      done16 = 1'b1;
   end

endmodule
